// File: rtl/glyph_pkg.sv
// Shared constants, colour width and FSM state type for the glyph pixel reader.
// Build option: GLYPH_SCALE2_EN selects 2x2 pixel replication (16x32 output cell).
package glyph_pkg;

    localparam int GLYPH_W = 8;
    localparam int GLYPH_H = 16;
    localparam int ROM_AW  = 7;
    localparam int RGB_W   = 16;

    // Output cell coordinate widths, wide enough for the scaled 16x32 cell.
    localparam int PIX_XW  = 4;
    localparam int PIX_YW  = 5;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        WAIT,
        SEND
    } glyph_rd_state_t;

endpackage

// File: rtl/glyph_pixel_reader_if.sv
// Pixel stream from the glyph reader to the TFT write controller.
// Master drives pixels and markers; slave returns pix_ready.
interface glyph_pixel_reader_if;
    import glyph_pkg::*;

    logic [RGB_W-1:0]  pix_data;
    logic              pix_valid;
    logic              pix_ready;
    logic [PIX_XW-1:0] pix_x;
    logic [PIX_YW-1:0] pix_y;
    logic              pix_last;

    modport master (
        output pix_data,
        output pix_valid,
        output pix_x,
        output pix_y,
        output pix_last,
        input  pix_ready
    );

    modport slave (
        input  pix_data,
        input  pix_valid,
        input  pix_x,
        input  pix_y,
        input  pix_last,
        output pix_ready
    );

endinterface

// File: rtl/glyph_scan_counter.sv
// Row-major x/y scan counters for one glyph cell, last-pixel flag and ROM
// address mapping. Build option: GLYPH_SCALE2_EN doubles the cell in both axes,
// each glyph bit being addressed by two consecutive x and two consecutive y.
module glyph_scan_counter
    import glyph_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              advance,
    output logic [PIX_XW-1:0] x,
    output logic [PIX_YW-1:0] y,
    output logic              last,
    output logic [ROM_AW-1:0] rom_address
);

`ifdef GLYPH_SCALE2_EN
    localparam logic [PIX_XW-1:0] X_MAX = PIX_XW'(2*GLYPH_W - 1);
    localparam logic [PIX_YW-1:0] Y_MAX = PIX_YW'(2*GLYPH_H - 1);
`else
    localparam logic [PIX_XW-1:0] X_MAX = PIX_XW'(GLYPH_W - 1);
    localparam logic [PIX_YW-1:0] Y_MAX = PIX_YW'(GLYPH_H - 1);
`endif

    // Step x across the row, wrapping into the next row; whole cell wraps to (0,0).
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            x <= '0;
            y <= '0;
        end else if (advance) begin
            if (x == X_MAX) begin
                x <= '0;
                y <= (y == Y_MAX) ? '0 : y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

    assign last = (x == X_MAX) && (y == Y_MAX);

`ifdef GLYPH_SCALE2_EN
    assign rom_address = {y[4:1], x[3:1]};
`else
    assign rom_address = {y[3:0], x[2:0]};
`endif

endmodule

// File: rtl/glyph_pixel_reader.sv
// Reads one glyph from a 1-bit registered ROM and streams it as RGB565 pixels
// with first-to-last row-major order, one FETCH/WAIT/SEND pass per pixel.
// Build option: GLYPH_SCALE2_EN renders each glyph bit as a 2x2 block.
module glyph_pixel_reader
    import glyph_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [RGB_W-1:0]     fg_color,
    input  logic [RGB_W-1:0]     bg_color,
    output logic [ROM_AW-1:0]    rom_address,
    input  logic                 rom_q,
    glyph_pixel_reader_if.master pix,
    output logic                 busy,
    output logic                 done
);

    glyph_rd_state_t   state;
    logic [RGB_W-1:0]  fg_q;
    logic [RGB_W-1:0]  bg_q;
    logic [PIX_XW-1:0] cnt_x;
    logic [PIX_YW-1:0] cnt_y;
    logic              cnt_last;
    logic              start_ok;
    logic              accept;

    // A start coinciding with the done pulse is dropped so restarts begin a cycle later.
    assign start_ok = start && (state == IDLE) && !done;
    assign accept   = (state == SEND) && pix.pix_ready;

    glyph_scan_counter u_scan (
        .clock       (clock),
        .reset       (reset),
        .clear       (start_ok),
        .advance     (accept),
        .x           (cnt_x),
        .y           (cnt_y),
        .last        (cnt_last),
        .rom_address (rom_address)
    );

    // Control FSM with registered pixel outputs, busy and done.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            pix.pix_data  <= '0;
            pix.pix_valid <= 1'b0;
            pix.pix_x     <= '0;
            pix.pix_y     <= '0;
            pix.pix_last  <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        fg_q  <= fg_color;
                        bg_q  <= bg_color;
                        busy  <= 1'b1;
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    state <= WAIT;
                end
                WAIT: begin
                    pix.pix_data  <= rom_q ? fg_q : bg_q;
                    pix.pix_x     <= cnt_x;
                    pix.pix_y     <= cnt_y;
                    pix.pix_last  <= cnt_last;
                    pix.pix_valid <= 1'b1;
                    state         <= SEND;
                end
                SEND: begin
                    if (pix.pix_ready) begin
                        pix.pix_valid <= 1'b0;
                        if (pix.pix_last) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            state <= FETCH;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
